skinny_inv_sbox8_hpc2_1_hs: RTL

First-order HPC2-masked inverse SKINNY 8-bit S-box with a valid/ready handshake, used on the decryption datapath of the masked SKINNY-128-384+ core. It captures two Boolean shares and 8 fresh random bits, then holds them stable internally for the full evaluation. It evaluates the inverse as eight registered nor-xor gadgets over 4 logic levels (8 cycles) and returns two output shares.

---
 rtl/skinny_inv_sbox8_hpc2_1_hs_pkg.sv | 17 +
 rtl/skinny_inv_sbox8_hpc2_1_hs_if.sv | 26 ++
 rtl/skinny_inv_sbox8_hpc2_1_hs_gadget.sv | 44 ++++
 rtl/skinny_inv_sbox8_hpc2_1_hs.sv | 116 +++++++++++
 4 files changed

// File: rtl/skinny_inv_sbox8_hpc2_1_hs_pkg.sv
// Shared constants, FSM state and share types for the masked SKINNY 8-bit S-box blocks.
// No logic; every S-box wrapper imports this package.
package skinny_sbox_pkg;

    localparam int SBOX_HPC2_LAT = 8;
    localparam int SBOX_W        = 8;
    localparam int SBOX_NGADGET  = 8;

    typedef logic [SBOX_W-1:0] sbox_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sbox_state_t;

endpackage

// File: rtl/skinny_inv_sbox8_hpc2_1_hs_if.sv
// Share-in / share-out valid-ready bundle of the masked inverse S-box.
// The slave modport is the S-box side, master is the producer/consumer side.
interface skinny_inv_sbox8_hpc2_1_hs_if;
    import skinny_sbox_pkg::*;

    sbox_byte_t si0;
    sbox_byte_t si1;
    sbox_byte_t r;
    logic       in_valid;
    logic       in_ready;
    sbox_byte_t bo0;
    sbox_byte_t bo1;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  si0, si1, r, in_valid, out_ready,
        output in_ready, bo0, bo1, out_valid
    );

    modport master (
        output si0, si1, r, in_valid, out_ready,
        input  in_ready, bo0, bo1, out_valid
    );

endinterface

// File: rtl/skinny_inv_sbox8_hpc2_1_hs_gadget.sv
// HPC2 nor-xor gadget f = nor(x,y) ^ z on two shares, one fresh bit r.
// Latency 2 cycles (x/y/r registered, then product xor z registered); no handshake, free-running.
module hpc2_1_inv_cfn_gadget (
    input  logic clk,
    input  logic rst_n,
    input  logic x0,
    input  logic x1,
    input  logic y0,
    input  logic y1,
    input  logic z0,
    input  logic z1,
    input  logic r,
    output logic f0,
    output logic f1
);

    // nor(x,y) = (~x) & (~y); inverting share 0 alone negates the shared value
    logic a0_q, a1_q, b0_q, b1_q, r_q, m0_q, m1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0_q <= 1'b0;
            a1_q <= 1'b0;
            b0_q <= 1'b0;
            b1_q <= 1'b0;
            r_q  <= 1'b0;
            m0_q <= 1'b0;
            m1_q <= 1'b0;
            f0   <= 1'b0;
            f1   <= 1'b0;
        end else begin
            a0_q <= ~x0;
            a1_q <= x1;
            b0_q <= ~y0;
            b1_q <= y1;
            r_q  <= r;
            m0_q <= y1 ^ r;
            m1_q <= ~y0 ^ r;
            f0   <= (a0_q & b0_q) ^ (~a0_q & r_q) ^ (a0_q & m0_q) ^ z0;
            f1   <= (a1_q & b1_q) ^ (~a1_q & r_q) ^ (a1_q & m1_q) ^ z1;
        end
    end

endmodule

// File: rtl/skinny_inv_sbox8_hpc2_1_hs.sv
// First-order HPC2 masked inverse SKINNY 8-bit S-box; optional SKINNY_INV_SBOX_CLR_EN zeroes bo0/bo1 unless out_valid.
// Latency 9 cycles accept-to-out_valid, one result per 10 cycles; holds result and stalls input while out_ready is low.
module skinny_inv_sbox8_hpc2_1_hs
    import skinny_sbox_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    skinny_inv_sbox8_hpc2_1_hs_if.slave   io
);

    sbox_byte_t  s0_q, s1_q, r_q;
    sbox_byte_t  b0_sh, b1_sh;
    sbox_state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        acc;

    assign io.in_ready  = rst_n & (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign acc          = io.in_valid & io.in_ready;

    // Operands stay frozen for the whole evaluation and while the result waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= '0;
            s1_q <= '0;
            r_q  <= '0;
        end else if (acc) begin
            s0_q <= io.si0;
            s1_q <= io.si1;
            r_q  <= io.r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = 3'(cnt_q + 3'd1);
                if (cnt_q == 3'(SBOX_HPC2_LAT - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Level 1: depends on input bits only
    hpc2_1_inv_cfn_gadget u_b2 (.clk(clk), .rst_n(rst_n),
        .x0(s0_q[3]), .x1(s1_q[3]), .y0(s0_q[1]), .y1(s1_q[1]),
        .z0(s0_q[0]), .z1(s1_q[0]), .r(r_q[0]), .f0(b0_sh[2]), .f1(b1_sh[2]));

    hpc2_1_inv_cfn_gadget u_b3 (.clk(clk), .rst_n(rst_n),
        .x0(s0_q[7]), .x1(s1_q[7]), .y0(s0_q[6]), .y1(s1_q[6]),
        .z0(s0_q[4]), .z1(s1_q[4]), .r(r_q[1]), .f0(b0_sh[3]), .f1(b1_sh[3]));

    hpc2_1_inv_cfn_gadget u_b7 (.clk(clk), .rst_n(rst_n),
        .x0(s0_q[2]), .x1(s1_q[2]), .y0(s0_q[7]), .y1(s1_q[7]),
        .z0(s0_q[1]), .z1(s1_q[1]), .r(r_q[2]), .f0(b0_sh[7]), .f1(b1_sh[7]));

    hpc2_1_inv_cfn_gadget u_b5 (.clk(clk), .rst_n(rst_n),
        .x0(s0_q[6]), .x1(s1_q[6]), .y0(s0_q[5]), .y1(s1_q[5]),
        .z0(s0_q[7]), .z1(s1_q[7]), .r(r_q[3]), .f0(b0_sh[5]), .f1(b1_sh[5]));

    // Level 2
    hpc2_1_inv_cfn_gadget u_b1 (.clk(clk), .rst_n(rst_n),
        .x0(s0_q[5]), .x1(s1_q[5]), .y0(b0_sh[3]), .y1(b1_sh[3]),
        .z0(s0_q[3]), .z1(s1_q[3]), .r(r_q[4]), .f0(b0_sh[1]), .f1(b1_sh[1]));

    hpc2_1_inv_cfn_gadget u_b0 (.clk(clk), .rst_n(rst_n),
        .x0(b0_sh[3]), .x1(b1_sh[3]), .y0(b0_sh[2]), .y1(b1_sh[2]),
        .z0(s0_q[5]), .z1(s1_q[5]), .r(r_q[5]), .f0(b0_sh[0]), .f1(b1_sh[0]));

    // Levels 3 and 4
    hpc2_1_inv_cfn_gadget u_b6 (.clk(clk), .rst_n(rst_n),
        .x0(b0_sh[2]), .x1(b1_sh[2]), .y0(b0_sh[1]), .y1(b1_sh[1]),
        .z0(s0_q[2]), .z1(s1_q[2]), .r(r_q[6]), .f0(b0_sh[6]), .f1(b1_sh[6]));

    hpc2_1_inv_cfn_gadget u_b4 (.clk(clk), .rst_n(rst_n),
        .x0(b0_sh[7]), .x1(b1_sh[7]), .y0(b0_sh[6]), .y1(b1_sh[6]),
        .z0(s0_q[6]), .z1(s1_q[6]), .r(r_q[7]), .f0(b0_sh[4]), .f1(b1_sh[4]));

`ifdef SKINNY_INV_SBOX_CLR_EN
    assign io.bo0 = b0_sh & {SBOX_W{io.out_valid}};
    assign io.bo1 = b1_sh & {SBOX_W{io.out_valid}};
`else
    assign io.bo0 = b0_sh;
    assign io.bo1 = b1_sh;
`endif

endmodule
